scoreboard_hazard_unit: RTL

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/mips_pipe_pkg.sv | 18 +
 rtl/scoreboard_hazard_unit_sb_entry.sv | 24 ++
 rtl/scoreboard_hazard_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants: forwarding-mux encodings and scoreboard width helpers.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Width of the producer-latency field (holds 0..max_lat).
  function automatic int unsigned lat_width(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

  // Width of a pending counter (holds 0..max_lat+1).
  function automatic int unsigned pcnt_width(input int unsigned max_lat);
    return $clog2(max_lat + 2);
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// One scoreboard slot: a pending-cycles counter that loads on reservation
// and otherwise counts down to zero.
module sb_entry #(
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] cnt
);

  // A reservation takes priority over the countdown in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - PW'(1);
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage scoreboard: tracks in-flight register writes, raises RAW/WAW stalls,
// selects operand forwarding and counts stall cycles.
module scoreboard_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W = 5,
  parameter  int unsigned MAX_LAT    = 4,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned LW         = lat_width(MAX_LAT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  input  logic                  issue_use_rs,
  input  logic                  issue_use_rt,
  input  logic                  issue_wr_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [LW-1:0]         issue_lat,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_fire,
  output logic [1:0]            fwd_sel_rs,
  output logic [1:0]            fwd_sel_rt,
  output logic                  busy_any,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned NREGS = 2 ** REG_ADDR_W;
  localparam int unsigned PW    = pcnt_width(MAX_LAT);

  logic [PW-1:0] pcnt [NREGS];
  logic [PW-1:0] leff;
  logic [PW-1:0] res_val;
  logic          rd_nz;
  logic          res_en;
  logic          haz_rs;
  logic          haz_rt;
  logic          waw;

  // Source is hazardous while its producer is still more than two cycles out.
  function automatic logic src_hazard(input logic                  use_src,
                                      input logic [REG_ADDR_W-1:0] idx,
                                      input logic [PW-1:0]         cnt);
    return use_src && (idx != '0) && (cnt > PW'(2));
  endfunction

  function automatic logic [1:0] fwd_decode(input logic                  use_src,
                                            input logic [REG_ADDR_W-1:0] idx,
                                            input logic [PW-1:0]         cnt);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && (idx != '0)) begin
      if (cnt == PW'(2)) begin
        sel = FWD_EXMEM;
      end else if (cnt == PW'(1)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  // Effective latency: 0 behaves as 1, anything above MAX_LAT is clamped.
  always_comb begin
    leff = PW'(issue_lat);
    if (issue_lat == '0) begin
      leff = PW'(1);
    end else if (32'(issue_lat) > MAX_LAT) begin
      leff = PW'(MAX_LAT);
    end
  end

  assign res_val = leff + PW'(1);
  assign rd_nz   = (issue_rd != '0);

  assign haz_rs = src_hazard(issue_use_rs, issue_rs, pcnt[issue_rs]);
  assign haz_rt = src_hazard(issue_use_rt, issue_rt, pcnt[issue_rt]);
  // A younger writer may not finish before an older write to the same register.
  assign waw    = issue_wr_en && rd_nz && (pcnt[issue_rd] > res_val);

  assign stall      = issue_valid & ~flush & (haz_rs | haz_rt | waw);
  assign issue_fire = issue_valid & ~stall & ~flush;
  assign res_en     = issue_fire & issue_wr_en & rd_nz;

  assign fwd_sel_rs = fwd_decode(issue_use_rs, issue_rs, pcnt[issue_rs]);
  assign fwd_sel_rt = fwd_decode(issue_use_rt, issue_rt, pcnt[issue_rt]);

  // r0 is hardwired: never reserved, always reads as idle.
  assign pcnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    sb_entry #(
      .PW (PW)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (res_en && (issue_rd == REG_ADDR_W'(r))),
      .load_val (res_val),
      .cnt      (pcnt[r])
    );
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      busy_any = busy_any | (pcnt[r] != '0);
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
